// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_pkg : opcode/funct constants, forwarding encodings, Tnew helper
// Rev 1.0
// ============================================================================
package hazard_ctrl_pkg;

   localparam logic [5:0] RTYPE  = 6'h00;
   localparam logic [5:0] R_ADDU = 6'h21;
   localparam logic [5:0] R_SUBU = 6'h23;
   localparam logic [5:0] R_JR   = 6'h08;
   localparam logic [5:0] ORI    = 6'h0d;
   localparam logic [5:0] LW     = 6'h23;
   localparam logic [5:0] SW     = 6'h2b;
   localparam logic [5:0] BEQ    = 6'h04;
   localparam logic [5:0] LUI    = 6'h0f;
   localparam logic [5:0] J      = 6'h02;
   localparam logic [5:0] JAL    = 6'h03;

   typedef enum logic [1:0] {
      FWD_GRF = 2'd0,
      FWD_E   = 2'd1,
      FWD_M   = 2'd2,
      FWD_W   = 2'd3
   } fwd_sel_e;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_if : D-stage instruction in, stall/flush and forwarding selects out
// Rev 1.0
// ============================================================================
interface hazard_ctrl_if;
   logic [31:0] instr_d;
   logic        stall;
   logic        flush_e;
   logic [1:0]  fwd_d_rs;
   logic [1:0]  fwd_d_rt;
   logic [1:0]  fwd_e_rs;
   logic [1:0]  fwd_e_rt;
   logic        fwd_m_rt;

   modport master (
      output instr_d,
      input  stall, flush_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
   );

   modport slave (
      input  instr_d,
      output stall, flush_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_hz_classify.sv
`default_nettype none
// ============================================================================
// hz_classify : combinational instruction -> {rs, rt, wreg, Tuse(rs/rt), Tnew}
// Rev 1.0
// ============================================================================
module hz_classify
   import hazard_ctrl_pkg::*;
#(
   parameter int NREG_BITS = 5,
   parameter int RA_REG    = 31
) (
   input  wire logic [31:0]          i_instr,
   output logic      [NREG_BITS-1:0] o_rs,
   output logic      [NREG_BITS-1:0] o_rt,
   output logic      [NREG_BITS-1:0] o_wreg,
   output logic      [1:0]           o_tuse_rs,
   output logic      [1:0]           o_tuse_rt,
   output logic      [1:0]           o_tnew
);
   logic [5:0]           w_op;
   logic [5:0]           w_fn;
   logic [NREG_BITS-1:0] w_rs_f;
   logic [NREG_BITS-1:0] w_rt_f;
   logic [NREG_BITS-1:0] w_rd_f;
   logic                 w_unused_shamt;

   assign w_op           = i_instr[31:26];
   assign w_fn           = i_instr[5:0];
   assign w_rs_f         = NREG_BITS'(i_instr[25:21]);
   assign w_rt_f         = NREG_BITS'(i_instr[20:16]);
   assign w_rd_f         = NREG_BITS'(i_instr[15:11]);
   assign w_unused_shamt = ^i_instr[10:6];

   always_comb begin
      o_wreg    = '0;
      o_tuse_rs = TUSE_NONE;
      o_tuse_rt = TUSE_NONE;
      o_tnew    = 2'd0;
      case (w_op)
         RTYPE: begin
            if (w_fn == R_ADDU || w_fn == R_SUBU) begin
               o_wreg    = w_rd_f;
               o_tuse_rs = 2'd1;
               o_tuse_rt = 2'd1;
               o_tnew    = 2'd1;
            end else if (w_fn == R_JR) begin
               o_tuse_rs = 2'd0;
            end
         end
         ORI: begin
            o_wreg    = w_rt_f;
            o_tuse_rs = 2'd1;
            o_tnew    = 2'd1;
         end
         LUI: begin
            o_wreg = w_rt_f;
            o_tnew = 2'd1;
         end
         LW: begin
            o_wreg    = w_rt_f;
            o_tuse_rs = 2'd1;
            o_tnew    = 2'd2;
         end
         SW: begin
            o_tuse_rs = 2'd1;
            o_tuse_rt = 2'd2;
         end
         BEQ: begin
            o_tuse_rs = 2'd0;
            o_tuse_rt = 2'd0;
         end
         JAL: begin
            o_wreg = NREG_BITS'(RA_REG);
         end
         default: ;
      endcase
   end

   // Unread source fields read as $0 so they can never raise a hazard or a forward.
   assign o_rs = (o_tuse_rs != TUSE_NONE) ? w_rs_f : '0;
   assign o_rt = (o_tuse_rt != TUSE_NONE) ? w_rt_f : '0;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : stall/flush and forwarding control for the D/E/M/W pipeline.
// Optional macro HAZARD_FWD_EN: forwarding + Tuse/Tnew stall; else pure interlock.
// Rev 1.0
// ============================================================================
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int NREG_BITS = 5,
   parameter int RA_REG    = 31
) (
   input  wire logic    clk,
   input  wire logic    reset,
   hazard_ctrl_if.slave bus
);
   logic [NREG_BITS-1:0] w_rs;
   logic [NREG_BITS-1:0] w_rt;
   logic [NREG_BITS-1:0] w_wreg;
   logic [1:0]           w_tuse_rs;
   logic [1:0]           w_tuse_rt;
   logic [1:0]           w_tnew;
   logic                 w_stall;

   logic [NREG_BITS-1:0] r_e_rs;
   logic [NREG_BITS-1:0] r_e_rt;
   logic [NREG_BITS-1:0] r_e_wreg;
   logic [1:0]           r_e_tnew;
   logic [NREG_BITS-1:0] r_m_rt;
   logic [NREG_BITS-1:0] r_m_wreg;
   logic [1:0]           r_m_tnew;
   logic [NREG_BITS-1:0] r_w_wreg;

   hz_classify #(
      .NREG_BITS (NREG_BITS),
      .RA_REG    (RA_REG)
   ) u_classify (
      .i_instr   (bus.instr_d),
      .o_rs      (w_rs),
      .o_rt      (w_rt),
      .o_wreg    (w_wreg),
      .o_tuse_rs (w_tuse_rs),
      .o_tuse_rt (w_tuse_rt),
      .o_tnew    (w_tnew)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_e_rs   <= '0;
         r_e_rt   <= '0;
         r_e_wreg <= '0;
         r_e_tnew <= '0;
         r_m_rt   <= '0;
         r_m_wreg <= '0;
         r_m_tnew <= '0;
         r_w_wreg <= '0;
      end else begin
         r_m_rt   <= r_e_rt;
         r_m_wreg <= r_e_wreg;
         r_m_tnew <= tnew_dec(r_e_tnew);
         r_w_wreg <= r_m_wreg;
         if (w_stall) begin
            r_e_rs   <= '0;
            r_e_rt   <= '0;
            r_e_wreg <= '0;
            r_e_tnew <= '0;
         end else begin
            r_e_rs   <= w_rs;
            r_e_rt   <= w_rt;
            r_e_wreg <= w_wreg;
            r_e_tnew <= w_tnew;
         end
      end
   end

`ifdef HAZARD_FWD_EN
   // A producer only blocks D if its value is not ready by the time D needs it.
   function automatic logic src_hazard(input logic [NREG_BITS-1:0] src, input logic [1:0] tuse);
      return (tuse != TUSE_NONE) && (src != '0) &&
             (((r_e_wreg == src) && (r_e_tnew > tuse)) ||
              ((r_m_wreg == src) && (r_m_tnew > tuse)));
   endfunction

   function automatic fwd_sel_e sel_d(input logic [NREG_BITS-1:0] src);
      if (src == '0)                                return FWD_GRF;
      if ((r_e_wreg == src) && (r_e_tnew == 2'd0))  return FWD_E;
      if ((r_m_wreg == src) && (r_m_tnew == 2'd0))  return FWD_M;
      if (r_w_wreg == src)                          return FWD_W;
      return FWD_GRF;
   endfunction

   function automatic fwd_sel_e sel_e(input logic [NREG_BITS-1:0] src);
      if (src == '0)                                return FWD_GRF;
      if ((r_m_wreg == src) && (r_m_tnew == 2'd0))  return FWD_M;
      if (r_w_wreg == src)                          return FWD_W;
      return FWD_GRF;
   endfunction

   assign bus.fwd_d_rs = reset ? FWD_GRF : sel_d(w_rs);
   assign bus.fwd_d_rt = reset ? FWD_GRF : sel_d(w_rt);
   assign bus.fwd_e_rs = reset ? FWD_GRF : sel_e(r_e_rs);
   assign bus.fwd_e_rt = reset ? FWD_GRF : sel_e(r_e_rt);
   assign bus.fwd_m_rt = ~reset & (r_m_rt != '0) & (r_m_rt == r_w_wreg);
`else
   // No bypass paths: any in-flight writer in E or M holds D until it reaches W.
   function automatic logic src_hazard(input logic [NREG_BITS-1:0] src, input logic [1:0] tuse);
      return (tuse != TUSE_NONE) && (src != '0) &&
             ((r_e_wreg == src) || (r_m_wreg == src));
   endfunction

   logic w_unused;
   assign w_unused = ^{r_e_rs, r_e_rt, r_e_tnew, r_m_rt, r_m_tnew, r_w_wreg};

   assign bus.fwd_d_rs = FWD_GRF;
   assign bus.fwd_d_rt = FWD_GRF;
   assign bus.fwd_e_rs = FWD_GRF;
   assign bus.fwd_e_rt = FWD_GRF;
   assign bus.fwd_m_rt = 1'b0;
`endif

   assign w_stall     = src_hazard(w_rs, w_tuse_rs) | src_hazard(w_rt, w_tuse_rt);
   assign bus.stall   = w_stall & ~reset;
   assign bus.flush_e = w_stall & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed bench with a pipeline-occupancy model for hazard_ctrl
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;
   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_ORI = 6'h0d;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_LUI = 6'h0f;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_JR   = 6'h08;
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   cmp_en = 1'b0;
   logic [31:0] hist [3];   // instruction words now in E, M, W

   always #5 clk = ~clk;

   hazard_ctrl_if bus();
   hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
      return {OP_R, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   // Destination, Tnew at E entry, Tuse per source (-1 = not read), read sources.
   function automatic void dec(input logic [31:0] w, output int dst, output int tnew,
                               output int urs, output int urt, output int rs, output int rt);
      int op = int'(w[31:26]);
      int fn = int'(w[5:0]);
      dst = 0; tnew = 0; urs = -1; urt = -1;
      if (op == OP_R && (fn == FN_ADDU || fn == FN_SUBU)) begin
         dst = int'(w[15:11]); tnew = 1; urs = 1; urt = 1;
      end else if (op == OP_R && fn == FN_JR) urs = 0;
      else if (op == OP_ORI) begin dst = int'(w[20:16]); tnew = 1; urs = 1; end
      else if (op == OP_LUI) begin dst = int'(w[20:16]); tnew = 1; end
      else if (op == OP_LW)  begin dst = int'(w[20:16]); tnew = 2; urs = 1; end
      else if (op == OP_SW)  begin urs = 1; urt = 2; end
      else if (op == OP_BEQ) begin urs = 0; urt = 0; end
      else if (op == OP_JAL) begin dst = 31; end
      rs = (urs >= 0) ? int'(w[25:21]) : 0;
      rt = (urt >= 0) ? int'(w[20:16]) : 0;
   endfunction

   function automatic bit hz(int src, int tuse, int dst[3], int tl[3]);
      if (src == 0 || tuse < 0) return 1'b0;
      for (int k = 0; k < 2; k++)
         if (dst[k] == src && (!FWD || tl[k] > tuse)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int fsel(int src, int first, int dst[3], int tl[3]);
      if (!FWD || src == 0) return 0;
      for (int k = first; k < 3; k++)
         if (dst[k] == src && (k == 2 || tl[k] == 0)) return k + 1;
      return 0;
   endfunction

   function automatic void model(input logic [31:0] d, output int st, output int fdrs,
                                 output int fdrt, output int fers, output int fert, output int fmrt);
      int dst[3], tl[3], srs[3], srt[3];
      int t, a, b, drs, drt, ud, td, ursd, urtd;
      for (int k = 0; k < 3; k++) begin
         dec(hist[k], dst[k], t, a, b, srs[k], srt[k]);
         tl[k] = (t > k) ? t - k : 0;
      end
      dec(d, ud, td, ursd, urtd, drs, drt);
      st   = int'(hz(drs, ursd, dst, tl) || hz(drt, urtd, dst, tl));
      fdrs = fsel(drs, 0, dst, tl);
      fdrt = fsel(drt, 0, dst, tl);
      fers = fsel(srs[0], 1, dst, tl);
      fert = fsel(srt[0], 1, dst, tl);
      fmrt = (FWD && srt[1] != 0 && srt[1] == dst[2]) ? 1 : 0;
      if (reset) begin st = 0; fdrs = 0; fdrt = 0; fers = 0; fert = 0; fmrt = 0; end
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
   endtask

   always @(posedge clk) begin
      int s, a, b, c, d, e;
      model(bus.instr_d, s, a, b, c, d, e);
      if (reset) begin
         hist[0] = '0; hist[1] = '0; hist[2] = '0;
      end else begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = (s != 0) ? 32'd0 : bus.instr_d;
      end
   end

   always @(negedge clk) begin
      int s, a, b, c, d, e;
      #2;
      if (cmp_en) begin
         model(bus.instr_d, s, a, b, c, d, e);
         chk("stall",    int'(bus.stall),    s);
         chk("flush_e",  int'(bus.flush_e),  s);
         chk("fwd_d_rs", int'(bus.fwd_d_rs), a);
         chk("fwd_d_rt", int'(bus.fwd_d_rt), b);
         chk("fwd_e_rs", int'(bus.fwd_e_rs), c);
         chk("fwd_e_rt", int'(bus.fwd_e_rt), d);
         chk("fwd_m_rt", int'(bus.fwd_m_rt), e);
      end
   end

   // Present one instruction in D and hold it until it is no longer stalled.
   task automatic issue(input logic [31:0] ins, output int nstall);
      int s, a, b, c, d, e;
      nstall = 0;
      @(negedge clk);
      bus.instr_d = ins;
      while (1) begin
         #1;
         model(ins, s, a, b, c, d, e);
         if (s == 0) break;
         nstall++;
         if (nstall > 6) begin
            n_chk++;
            $display("FAIL stall_bound at %0t: got %0d stall cycles, limit 6", $time, nstall);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int n;
      repeat (3) issue(32'd0, n);
   endtask

   initial begin
      int n;
      logic [31:0] w;
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
      reset = 1'b1;
      bus.instr_d = i_ins(OP_LW, 0, 1, 0);
      cmp_en = 1'b1;
      @(posedge clk); #1;
      chk("rst_stall",    int'(bus.stall),    0);
      chk("rst_fwd_d_rs", int'(bus.fwd_d_rs), 0);
      @(posedge clk); #1;
      chk("rst_flush_e",  int'(bus.flush_e),  0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_stall",    int'(bus.stall),    0);
      chk("post_rst_fwd_e_rs", int'(bus.fwd_e_rs), 0);

      // lw $1 (already in D) -> beq $1,$2
      issue(i_ins(OP_BEQ, 1, 2, 4), n);
      chk("lw_beq_stalls",   n, 2);
      chk("lw_beq_fwd_d_rs", int'(bus.fwd_d_rs), FWD ? 3 : 0);
      drain();

      // lw $1 -> addu $3,$1,$2
      issue(i_ins(OP_LW, 0, 1, 0), n);
      issue(r_ins(1, 2, 3, FN_ADDU), n);
      chk("lw_addu_stalls", n, FWD ? 1 : 2);
      issue(32'd0, n);
      chk("lw_addu_fwd_e_rs", int'(bus.fwd_e_rs), FWD ? 3 : 0);
      drain();

      // addu $1 -> addu $2,$1,$1
      issue(r_ins(2, 3, 1, FN_ADDU), n);
      issue(r_ins(1, 1, 2, FN_ADDU), n);
      chk("addu_addu_stalls", n, FWD ? 0 : 2);
      issue(32'd0, n);
      chk("addu_addu_fwd_e_rs", int'(bus.fwd_e_rs), FWD ? 2 : 0);
      chk("addu_addu_fwd_e_rt", int'(bus.fwd_e_rt), FWD ? 2 : 0);
      drain();

      // addu $1 -> beq $1,$0
      issue(r_ins(2, 3, 1, FN_ADDU), n);
      issue(i_ins(OP_BEQ, 1, 0, 2), n);
      chk("addu_beq_stalls", n, FWD ? 1 : 2);
      drain();

      // jal -> jr $31
      issue({OP_JAL, 26'h40}, n);
      issue(r_ins(31, 0, 0, FN_JR), n);
      chk("jal_jr_stalls",   n, FWD ? 0 : 2);
      chk("jal_jr_fwd_d_rs", int'(bus.fwd_d_rs), FWD ? 1 : 0);
      drain();

      // Writer of $0 followed by readers of $0
      issue(i_ins(OP_ORI, 0, 0, 5), n);
      issue(i_ins(OP_BEQ, 0, 0, 1), n);
      chk("zero_stalls",   n, 0);
      chk("zero_fwd_d_rs", int'(bus.fwd_d_rs), 0);
      chk("zero_fwd_d_rt", int'(bus.fwd_d_rt), 0);
      drain();

      // lw $5 -> sw $5,0($0)
      issue(i_ins(OP_LW, 0, 5, 0), n);
      issue(i_ins(OP_SW, 0, 5, 0), n);
      chk("lw_sw_stalls", n, FWD ? 0 : 2);
      issue(32'd0, n);
      issue(32'd0, n);
      chk("lw_sw_fwd_m_rt", int'(bus.fwd_m_rt), FWD ? 1 : 0);
      drain();

      // Reset while beq waits on lw: pending hazard is discarded
      issue(i_ins(OP_LW, 0, 1, 0), n);
      @(negedge clk);
      bus.instr_d = i_ins(OP_BEQ, 1, 2, 4);
      #1;
      chk("midrst_pre_stall", int'(bus.stall), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_post_stall", int'(bus.stall), 0);
      drain();

      // Mixed stream over a few registers, checked cycle by cycle by the model
      for (int i = 0; i < 60; i++) begin
         int ra = int'($urandom_range(0, 3));
         int rb = int'($urandom_range(0, 3));
         int rc = int'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0: w = r_ins(ra, rb, rc, FN_ADDU);
            1: w = r_ins(ra, rb, rc, FN_SUBU);
            2: w = i_ins(OP_ORI, ra, rb, 7);
            3: w = i_ins(OP_LUI, 0, rb, 1);
            4: w = i_ins(OP_LW, ra, rb, 0);
            5: w = i_ins(OP_SW, ra, rb, 0);
            6: w = i_ins(OP_BEQ, ra, rb, 1);
            7: w = r_ins(ra, 0, 0, FN_JR);
            8: w = {OP_JAL, 26'h80};
            default: w = 32'd0;
         endcase
         issue(w, n);
      end
      drain();

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
